clock_divider_nch: RTL and testbench
====================================

# clock_divider_nch

Multi-channel, parametrised clock divider and tick generator. It derives NUM_CH independent divided outputs from a single `clk_in`. Each channel has its own divide value, toggle/pulse mode, enable, and a per-period tick strobe. All logic is synchronous to `clk_in`, so there are no derived-clock flops. Divide and mode changes are glitch-free, and a common `sync_start` phase-aligns all channels. The block drives AXI-side peripheral timing (bus-sim slave pacing, sample strobes) from the system clock.

## Interface
- CNT_WIDTH, 32, width of each channel's counter and divide value
- NUM_CH, 4, number of independent channels (≥1)
- clk_in  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  NUM_CH  per-channel run enable; level-sensitive
- clk_div  input  NUM_CH*CNT_WIDTH  divide values, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
- mode  input  NUM_CH  per channel: 0 = toggle (square wave), 1 = pulse (one-cycle high per period)
- sync_start  input  1  one-cycle request to restart all running channels at phase 0
- clk_out  output  NUM_CH  registered divided output per channel
- tick  output  NUM_CH  registered one-cycle strobe at each channel period boundary

## Operation
- Per-channel state:
  - `running` flag
  - counter `cnt` [CNT_WIDTH]
  - shadow divide value `div_act`
  - shadow mode `mode_act`
  - `clk_out` register
  - `tick` register
- Idle (running=0):
  - cnt=0, clk_out=0, tick=0.
  - div_act and mode_act load from the inputs every cycle.
  - enable=1 sampled → running=1, cnt=0, no output change.
- Running, cnt≠div_act: cnt←cnt+1; clk_out holds; tick=0.
- Running, cnt==div_act (terminal):
  - cnt←0; tick←1.
  - div_act and mode_act reload from the inputs.
  - mode_act=0: clk_out←~clk_out.
  - mode_act=1: clk_out←1.
  - In pulse mode clk_out is otherwise driven 0 on every non-terminal cycle.
- Divide/mode inputs affect a running channel only at a terminal count, so periods are never truncated or stretched mid-way.
  - cnt never exceeds div_act.
  - Equality compare only; no wrap-around possible.
- Periods:
  - Toggle mode: full period 2(D+1) clk_in cycles, 50% duty.
  - Pulse mode: period D+1 cycles, high 1 cycle.
- D=0:
  - Toggle mode gives clk_in/2.
  - Pulse mode gives clk_out and tick constantly high while running.
- enable=0 while running: next edge → idle (cnt=0, clk_out=0, tick=0), regardless of terminal.
- sync_start=1: every running channel gets cnt←0, clk_out←0, tick←0, and reloads div_act/mode_act. Idle channels are unaffected.
- Priority per channel: reset > enable=0 > sync_start > terminal > count.
- Channels are fully independent apart from sync_start.

## Timing
- Reset (asynchronous assert, any time):
  - clk_out=0, tick=0, cnt=0, running=0, div_act=0, mode_act=0.
  - Reset mid-period discards phase; on release the channel restarts from idle.
- Enable sampled high at edge E0:
  - Toggle mode: first clk_out rise and first tick at edge E0+D+1.
  - Pulse mode: first clk_out pulse and first tick at edge E0+D+1.
- tick coincides with each clk_out update edge in both modes. It is high exactly one cycle, or continuously for D=0.
- sync_start at edge S: the next terminal, and the next tick, occur at edge S+D+1, where D is clk_div sampled at S.
- Output-to-input latency: 1 cycle.
- No combinational paths from inputs to outputs.

## Test plan
- Toggle divide, ch0 D=3, enable after reset: rising clk_out edges every 8 cycles, first at E0+4; tick at E0+4, E0+8, E0+12 …
- Pulse mode, ch1 D=4: clk_out high 1 cycle in every 5, equal to tick; D=0: clk_out and tick held high while enabled.
- Glitch-free reprogram, ch0 D=9 → D=2 written at cnt=5: current half-period completes (10 cycles); subsequent half-periods are 3 cycles; no runt pulse.
- Enable drop and reset mid-period: enable=0 at cnt=5, D=9 → clk_out=0 and tick=0 next edge, restart reproduces the first-edge timing; async reset asserted mid-cycle → all outputs 0 immediately.
- sync_start: ch0 D=3 and ch2 D=7 free-running with arbitrary phase, pulse sync_start → both clk_out=0 next edge; rising edges at S+4 and S+8; sync_start coincident with terminal → sync wins, no tick.
- Max width: CNT_WIDTH=8, D=255 → toggle half-period 256 cycles, no counter wrap; NUM_CH=1 build elaborates and passes the toggle scenario.

Source files
------------

// File: rtl/clock_divider_nch.sv
// rtl/clock_divider_nch.sv - multi-channel clock divider and tick generator synchronous to clk_in
module clock_divider_nch #(
    parameter int CNT_WIDTH = 32,
    parameter int NUM_CH    = 4
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           enable,
    input  logic [NUM_CH*CNT_WIDTH-1:0] clk_div,
    input  logic [NUM_CH-1:0]           mode,
    input  logic                        sync_start,
    output logic [NUM_CH-1:0]           clk_out,
    output logic [NUM_CH-1:0]           tick
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        logic                 running;
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] div_act;
        logic                 mode_act;
        logic                 out_q;
        logic                 tick_q;
        logic [CNT_WIDTH-1:0] div_in;
        logic                 terminal;

        assign div_in   = clk_div[g*CNT_WIDTH +: CNT_WIDTH];
        assign terminal = (cnt == div_act);

        // Per-channel divider: divide/mode are only taken from the inputs while idle,
        // on sync_start, or at a terminal count, so a running period is never cut short.
        always_ff @(posedge clk_in or negedge reset) begin
            if (!reset) begin
                running  <= 1'b0;
                cnt      <= '0;
                div_act  <= '0;
                mode_act <= 1'b0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else if (!running) begin
                cnt      <= '0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
                div_act  <= div_in;
                mode_act <= mode[g];
                running  <= enable[g];
            end else if (!enable[g]) begin
                running  <= 1'b0;
                cnt      <= '0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else if (sync_start) begin
                cnt      <= '0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
                div_act  <= div_in;
                mode_act <= mode[g];
            end else if (terminal) begin
                cnt      <= '0;
                tick_q   <= 1'b1;
                out_q    <= mode_act ? 1'b1 : ~out_q;
                div_act  <= div_in;
                mode_act <= mode[g];
            end else begin
                cnt      <= cnt + CNT_ONE;
                tick_q   <= 1'b0;
                if (mode_act) begin
                    out_q <= 1'b0;
                end
            end
        end

        assign clk_out[g] = out_q;
        assign tick[g]    = tick_q;
    end

endmodule

// File: tb/tb_clock_divider_nch.sv
// tb/tb_clock_divider_nch.sv - self-checking bench for clock_divider_nch
module tb_clock_divider_nch;

    localparam int CW = 32;
    localparam int NC = 4;

    logic              clk_in = 1'b0;
    logic              reset;
    logic [NC-1:0]     enable, mode, clk_out, tick;
    logic [NC*CW-1:0]  clk_div;
    logic              sync_start;
    logic [0:0]        enable_n, mode_n, clk_out_n, tick_n;
    logic [7:0]        clk_div_n;
    logic [9:0]        act;

    int     tests = 0;
    int     fails = 0;
    longint t = 0;

    bit     m_run[5];
    bit     m_out[5];
    bit     m_tick[5];
    bit     m_mode[5];
    longint m_next[5];

    always #5 clk_in = ~clk_in;

    clock_divider_nch #(.CNT_WIDTH(CW), .NUM_CH(NC)) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable), .clk_div(clk_div),
        .mode(mode), .sync_start(sync_start), .clk_out(clk_out), .tick(tick)
    );

    clock_divider_nch #(.CNT_WIDTH(8), .NUM_CH(1)) dut_w8 (
        .clk_in(clk_in), .reset(reset), .enable(enable_n), .clk_div(clk_div_n),
        .mode(mode_n), .sync_start(sync_start), .clk_out(clk_out_n), .tick(tick_n)
    );

    assign act = {tick_n, tick, clk_out_n, clk_out};

    function automatic longint div_of(int c);
        if (c < 4) return longint'(clk_div[c*CW +: CW]);
        return longint'(clk_div_n);
    endfunction

    function automatic bit en_of(int c);
        if (c < 4) return enable[c];
        return enable_n[0];
    endfunction

    function automatic bit mode_of(int c);
        if (c < 4) return mode[c];
        return mode_n[0];
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [9:0] v;
        for (int c = 0; c < 4; c++) begin
            v[c]   = m_out[c];
            v[5+c] = m_tick[c];
        end
        v[4] = m_out[4];
        v[9] = m_tick[4];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 5; c++) begin
            m_run[c] = 0; m_out[c] = 0; m_tick[c] = 0; m_mode[c] = 0; m_next[c] = 0;
        end
    endtask

    // Reference: each running channel knows the absolute edge of its next period boundary.
    task automatic step();
        t++;
        for (int c = 0; c < 5; c++) begin
            longint d;
            bit en, md;
            d  = div_of(c);
            en = en_of(c);
            md = mode_of(c);
            if (!m_run[c]) begin
                m_out[c] = 0; m_tick[c] = 0; m_mode[c] = md;
                if (en) begin m_run[c] = 1; m_next[c] = t + d + 1; end
            end else if (!en) begin
                m_run[c] = 0; m_out[c] = 0; m_tick[c] = 0;
            end else if (sync_start) begin
                m_out[c] = 0; m_tick[c] = 0; m_mode[c] = md; m_next[c] = t + d + 1;
            end else if (t == m_next[c]) begin
                m_tick[c] = 1;
                m_out[c]  = m_mode[c] ? 1'b1 : ~m_out[c];
                m_mode[c] = md;
                m_next[c] = t + d + 1;
            end else begin
                m_tick[c] = 0;
                if (m_mode[c]) m_out[c] = 0;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic quiesce();
        enable = '0; enable_n = '0; sync_start = 0; mode = '0; mode_n = '0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 0; enable = '0; mode = '0; clk_div = '0; sync_start = 0;
        enable_n = '0; mode_n = '0; clk_div_n = '0;
        model_reset();
        #22;
        tests++;
        if (act !== 10'b0) begin fails++; $display("FAIL reset_outputs act=%h exp=%h", act, 10'b0); end
        reset = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (act !== exp_vec()) begin fails++; $display("FAIL reset_idle t=%0d act=%h exp=%h", t, act, exp_vec()); end
        end
    endtask

    task automatic test_toggle();
        quiesce();
        clk_div[0*CW +: CW] = 3;
        enable[0] = 1;
        step();
        for (int k = 1; k <= 16; k++) begin
            bit eo, et;
            step();
            eo = ((k / 4) % 2) == 1;
            et = (k % 4) == 0;
            tests++;
            if (act !== exp_vec()) begin fails++; $display("FAIL toggle_model t=%0d act=%h exp=%h", t, act, exp_vec()); end
            tests++;
            if (clk_out[0] !== eo || tick[0] !== et) begin
                fails++; $display("FAIL toggle_edges k=%0d clk_out=%b tick=%b exp %b %b", k, clk_out[0], tick[0], eo, et);
            end
        end
    endtask

    task automatic test_pulse();
        quiesce();
        clk_div[1*CW +: CW] = 4;
        mode[1] = 1;
        enable[1] = 1;
        step();
        for (int k = 1; k <= 15; k++) begin
            bit e;
            step();
            e = (k % 5) == 0;
            tests++;
            if (act !== exp_vec()) begin fails++; $display("FAIL pulse_model t=%0d act=%h exp=%h", t, act, exp_vec()); end
            tests++;
            if (clk_out[1] !== e || tick[1] !== e) begin
                fails++; $display("FAIL pulse_d4 k=%0d clk_out=%b tick=%b exp %b", k, clk_out[1], tick[1], e);
            end
        end
        enable[1] = 0;
        step();
        clk_div[1*CW +: CW] = 0;
        enable[1] = 1;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
            tests++;
            if (clk_out[1] !== 1'b1 || tick[1] !== 1'b1) begin
                fails++; $display("FAIL pulse_d0 k=%0d clk_out=%b tick=%b exp 1 1", k, clk_out[1], tick[1]);
            end
        end
    endtask

    task automatic test_reprogram();
        logic prev;
        quiesce();
        clk_div[0*CW +: CW] = 9;
        enable[0] = 1;
        step();
        for (int k = 1; k <= 5; k++) step();
        clk_div[0*CW +: CW] = 2;
        prev = clk_out[0];
        for (int k = 6; k <= 25; k++) begin
            bit ec;
            step();
            ec = (k >= 10) && (((k - 10) % 3) == 0);
            tests++;
            if (act !== exp_vec()) begin fails++; $display("FAIL reprog_model t=%0d act=%h exp=%h", t, act, exp_vec()); end
            tests++;
            if ((clk_out[0] !== prev) !== ec) begin
                fails++; $display("FAIL reprog_change k=%0d changed=%b exp=%b", k, clk_out[0] !== prev, ec);
            end
            prev = clk_out[0];
        end
    endtask

    task automatic test_enable_drop();
        quiesce();
        clk_div[0*CW +: CW] = 9;
        enable[0] = 1;
        step();
        for (int k = 1; k <= 15; k++) step();
        tests++;
        if (clk_out[0] !== 1'b1) begin fails++; $display("FAIL drop_pre clk_out=%b exp=1", clk_out[0]); end
        enable[0] = 0;
        step();
        tests++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
            fails++; $display("FAIL drop_idle clk_out=%b tick=%b exp 0 0", clk_out[0], tick[0]);
        end
        enable[0] = 1;
        step();
        for (int k = 1; k <= 12; k++) begin
            step();
            tests++;
            if (clk_out[0] !== (k >= 10) || tick[0] !== (k == 10)) begin
                fails++; $display("FAIL drop_restart k=%0d clk_out=%b tick=%b exp %b %b", k, clk_out[0], tick[0], k >= 10, k == 10);
            end
        end
        #2;
        reset = 0;
        #1;
        model_reset();
        tests++;
        if (act !== 10'b0) begin fails++; $display("FAIL async_reset act=%h exp=%h", act, 10'b0); end
        #2;
        reset = 1;
        step();
        for (int k = 1; k <= 11; k++) begin
            step();
            tests++;
            if (act !== exp_vec()) begin fails++; $display("FAIL reset_restart t=%0d act=%h exp=%h", t, act, exp_vec()); end
        end
    endtask

    task automatic test_sync();
        int guard;
        quiesce();
        clk_div[0*CW +: CW] = 3;
        clk_div[2*CW +: CW] = 7;
        enable[0] = 1;
        step();
        repeat ($urandom_range(1, 9)) step();
        enable[2] = 1;
        repeat ($urandom_range(1, 9)) step();
        sync_start = 1;
        step();
        sync_start = 0;
        tests++;
        if (clk_out[0] !== 1'b0 || clk_out[2] !== 1'b0 || tick[0] !== 1'b0 || tick[2] !== 1'b0) begin
            fails++; $display("FAIL sync_clear clk_out=%b tick=%b exp 0", clk_out, tick);
        end
        for (int k = 1; k <= 9; k++) begin
            step();
            tests++;
            if (act !== exp_vec()) begin fails++; $display("FAIL sync_model t=%0d act=%h exp=%h", t, act, exp_vec()); end
            tests++;
            if (clk_out[0] !== (k >= 4 && k < 8) || clk_out[2] !== (k >= 8)) begin
                fails++; $display("FAIL sync_phase k=%0d ch0=%b ch2=%b exp %b %b", k, clk_out[0], clk_out[2], k >= 4 && k < 8, k >= 8);
            end
        end
        guard = 0;
        while (m_next[0] != t + 1 && guard < 20) begin
            step();
            guard++;
        end
        tests++;
        if (guard >= 20) begin fails++; $display("FAIL sync_align timeout guard=%0d limit=20", guard); end
        sync_start = 1;
        step();
        sync_start = 0;
        tests++;
        if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
            fails++; $display("FAIL sync_vs_terminal tick=%b clk_out=%b exp 0 0", tick[0], clk_out[0]);
        end
    endtask

    task automatic test_random();
        quiesce();
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 15) == 0) enable[c] = ~enable[c];
                if ($urandom_range(0, 7) == 0) clk_div[c*CW +: CW] = $urandom_range(0, 6);
                if ($urandom_range(0, 9) == 0) mode[c] = ~mode[c];
            end
            if ($urandom_range(0, 15) == 0) enable_n = ~enable_n;
            if ($urandom_range(0, 7) == 0) clk_div_n = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) mode_n = ~mode_n;
            sync_start = ($urandom_range(0, 30) == 0);
            step();
            tests++;
            if (act !== exp_vec()) begin fails++; $display("FAIL random t=%0d act=%h exp=%h", t, act, exp_vec()); end
        end
        sync_start = 0;
    endtask

    task automatic test_max_width();
        quiesce();
        clk_div_n = 8'd255;
        enable_n = 1'b1;
        step();
        for (int k = 1; k <= 520; k++) begin
            step();
            tests++;
            if (clk_out_n[0] !== (k >= 256 && k < 512) || tick_n[0] !== (k == 256 || k == 512)) begin
                fails++; $display("FAIL max_width k=%0d clk_out=%b tick=%b exp %b %b", k, clk_out_n[0], tick_n[0], k >= 256 && k < 512, k == 256 || k == 512);
            end
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_pulse();
        test_reprogram();
        test_enable_drop();
        test_sync();
        test_random();
        test_max_width();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
